// File: rtl/lc3_memaccess_fsm.sv
// rtl/lc3_memaccess_fsm.sv - LC3 memory-access stage sequencer with variable-latency bus and timeout abort
module lc3_memaccess_fsm #(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mem_start,
   input  logic [15:0] IR_Exec,
   input  logic [15:0] M_Addr,
   input  logic [15:0] M_Data,
   input  logic [15:0] Data_dout,
   input  logic        complete_data,
   output logic [15:0] Data_addr,
   output logic [15:0] Data_din,
   output logic        Data_rd,
   output logic [1:0]  mem_state,
   output logic [15:0] memout,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        mem_err
);

   typedef enum logic [1:0] {
      S_READ  = 2'd0,
      S_IND   = 2'd1,
      S_WRITE = 2'd2,
      S_IDLE  = 2'd3
   } state_t;

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

   state_t          r_state;
   logic [15:0]     r_addr;
   logic [15:0]     r_data;
   logic [15:0]     r_din;
   logic [15:0]     r_memout;
   logic            r_rd;
   logic            r_busy;
   logic            r_done;
   logic            r_err;
   logic            r_sti;
   logic [CW-1:0]   r_cnt;

   logic [3:0]      w_op;
   logic            w_unused_ir;

   assign w_op        = IR_Exec[15:12];
   assign w_unused_ir = ^IR_Exec[11:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_addr   <= 16'h0000;
         r_data   <= 16'h0000;
         r_din    <= 16'h0000;
         r_memout <= 16'h0000;
         r_rd     <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_sti    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (mem_start) begin
                  r_data <= M_Data;
                  r_sti  <= (w_op == 4'b1011);
                  r_cnt  <= '0;
                  case (w_op)
                     4'b0010, 4'b0110: begin
                        r_state <= S_READ;
                        r_addr  <= M_Addr;
                        r_busy  <= 1'b1;
                     end
                     4'b1010, 4'b1011: begin
                        r_state <= S_IND;
                        r_addr  <= M_Addr;
                        r_busy  <= 1'b1;
                     end
                     4'b0011, 4'b0111: begin
                        r_state <= S_WRITE;
                        r_addr  <= M_Addr;
                        r_din   <= M_Data;
                        r_rd    <= 1'b0;
                        r_busy  <= 1'b1;
                     end
                     // non-memory opcode: acknowledge without touching the bus
                     default: r_done <= 1'b1;
                  endcase
               end
            end
            default: begin
               if (complete_data) begin
                  r_cnt <= '0;
                  if (r_state == S_IND) begin
                     r_addr <= Data_dout;
                     if (r_sti) begin
                        r_state <= S_WRITE;
                        r_din   <= r_data;
                        r_rd    <= 1'b0;
                     end else begin
                        r_state <= S_READ;
                     end
                  end else begin
                     if (r_state == S_READ) begin
                        r_memout <= Data_dout;
                     end
                     r_state <= S_IDLE;
                     r_addr  <= 16'h0000;
                     r_din   <= 16'h0000;
                     r_rd    <= 1'b1;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end else if (r_cnt == LAST_WAIT) begin
                  r_state <= S_IDLE;
                  r_addr  <= 16'h0000;
                  r_din   <= 16'h0000;
                  r_rd    <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
         endcase
      end
   end

   assign Data_addr = r_addr;
   assign Data_din  = r_din;
   assign Data_rd   = r_rd;
   assign mem_state = r_state;
   assign memout    = r_memout;
   assign mem_busy  = r_busy;
   assign mem_done  = r_done;
   assign mem_err   = r_err;

endmodule

// File: tb/tb_lc3_memaccess_fsm.sv
// tb/tb_lc3_memaccess_fsm.sv - directed and randomized self-checking bench for lc3_memaccess_fsm
module tb_lc3_memaccess_fsm;
   localparam int TO = 15;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_start = 1'b0;
   logic        complete_data = 1'b0;
   logic [15:0] IR_Exec = 16'h0000;
   logic [15:0] M_Addr = 16'h0000;
   logic [15:0] M_Data = 16'h0000;
   logic [15:0] Data_dout = 16'h0000;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic        Data_rd;
   logic [1:0]  mem_state;
   logic [15:0] memout;
   logic        mem_busy;
   logic        mem_done;
   logic        mem_err;

   int n_cmp = 0;
   int n_bad = 0;

   // model: queue of bus accesses still owed by the current op (0 read, 1 pointer, 2 write)
   int          q[$];
   logic [15:0] m_addr, m_data, m_memout;
   bit          m_done, m_err, m_valid;
   int          dwell;

   lc3_memaccess_fsm #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .mem_start(mem_start), .IR_Exec(IR_Exec),
      .M_Addr(M_Addr), .M_Data(M_Data), .Data_dout(Data_dout),
      .complete_data(complete_data), .Data_addr(Data_addr), .Data_din(Data_din),
      .Data_rd(Data_rd), .mem_state(mem_state), .memout(memout),
      .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   function automatic void check16(string name, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_step();
      if (reset) begin
         q.delete();
         m_addr = 16'h0; m_data = 16'h0; m_memout = 16'h0;
         m_done = 1'b0; m_err = 1'b0; dwell = 0; m_valid = 1'b1;
      end else begin
         m_done = 1'b0;
         m_err  = 1'b0;
         if (q.size() == 0) begin
            if (mem_start) begin
               m_addr = M_Addr;
               m_data = M_Data;
               dwell  = 0;
               case (IR_Exec[15:12])
                  4'h2, 4'h6: q.push_back(0);
                  4'hA: begin q.push_back(1); q.push_back(0); end
                  4'hB: begin q.push_back(1); q.push_back(2); end
                  4'h3, 4'h7: q.push_back(2);
                  default: m_done = 1'b1;
               endcase
            end
         end else begin
            dwell++;
            if (complete_data) begin
               if (q[0] == 0) m_memout = Data_dout;
               if (q[0] == 1) m_addr = Data_dout;
               void'(q.pop_front());
               dwell = 0;
               if (q.size() == 0) m_done = 1'b1;
            end else if (dwell >= TO) begin
               q.delete();
               m_done = 1'b1;
               m_err  = 1'b1;
            end
         end
      end
   endtask

   always @(negedge clock) begin : compare
      int es;
      if (m_valid) begin
         es = (q.size() == 0) ? 3 : q[0];
         check16("mem_state", 16'(mem_state), 16'(es));
         check16("Data_rd",   16'(Data_rd),   16'(es != 2));
         check16("Data_addr", Data_addr,      (es == 3) ? 16'h0 : m_addr);
         check16("Data_din",  Data_din,       (es == 2) ? m_data : 16'h0);
         check16("memout",    memout,         m_memout);
         check16("mem_busy",  16'(mem_busy),  16'(es != 3));
         check16("mem_done",  16'(mem_done),  16'(m_done));
         check16("mem_err",   16'(mem_err),   16'(m_err));
      end
      model_step();
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic start_op(input logic [15:0] ir, input logic [15:0] a, input logic [15:0] d);
      mem_start = 1'b1; IR_Exec = ir; M_Addr = a; M_Data = d;
   endtask

   initial begin : stim
      logic [3:0] ops [8];
      int p;
      ops = '{4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hF};
      p = 50;
      repeat (3) step();
      check16("rst_state", 16'(mem_state), 16'd3);
      check16("rst_rd", 16'(Data_rd), 16'd1);
      check16("rst_memout", memout, 16'h0000);
      reset = 1'b0;

      // LD, zero-wait
      start_op(16'h2005, 16'h3010, 16'h0000);
      step(); mem_start = 1'b0;
      check16("ld_state", 16'(mem_state), 16'd0);
      check16("ld_addr", Data_addr, 16'h3010);
      complete_data = 1'b1; Data_dout = 16'hBEEF;
      step(); complete_data = 1'b0;
      check16("ld_done", 16'(mem_done), 16'd1);
      check16("ld_memout", memout, 16'hBEEF);
      check16("ld_idle", 16'(mem_state), 16'd3);

      // LDR timeout
      start_op(16'h6000, 16'h3100, 16'h0000);
      step(); mem_start = 1'b0;
      repeat (14) step();
      check16("to_still_read", 16'(mem_state), 16'd0);
      step();
      check16("to_done", 16'(mem_done), 16'd1);
      check16("to_err", 16'(mem_err), 16'd1);
      check16("to_memout", memout, 16'hBEEF);

      // LDR completing exactly on the last allowed cycle
      start_op(16'h6000, 16'h3100, 16'h0000);
      step(); mem_start = 1'b0;
      repeat (14) step();
      complete_data = 1'b1; Data_dout = 16'h0A0B;
      step(); complete_data = 1'b0;
      check16("edge_done", 16'(mem_done), 16'd1);
      check16("edge_err", 16'(mem_err), 16'd0);
      check16("edge_memout", memout, 16'h0A0B);

      // STI with two wait cycles per access
      start_op(16'hB000, 16'h3020, 16'h1234);
      step(); mem_start = 1'b0;
      check16("sti_ind", 16'(mem_state), 16'd1);
      check16("sti_ptr_addr", Data_addr, 16'h3020);
      step(); step();
      complete_data = 1'b1; Data_dout = 16'h4000;
      step(); complete_data = 1'b0;
      check16("sti_write", 16'(mem_state), 16'd2);
      check16("sti_addr", Data_addr, 16'h4000);
      check16("sti_din", Data_din, 16'h1234);
      check16("sti_rd", 16'(Data_rd), 16'd0);
      step(); step();
      complete_data = 1'b1;
      step(); complete_data = 1'b0;
      check16("sti_done", 16'(mem_done), 16'd1);
      check16("sti_memout", memout, 16'h0A0B);

      // non-memory opcode
      start_op(16'h1005, 16'h0000, 16'h0000);
      step(); mem_start = 1'b0;
      check16("add_done", 16'(mem_done), 16'd1);
      check16("add_state", 16'(mem_state), 16'd3);
      step();
      check16("add_pulse", 16'(mem_done), 16'd0);

      // LDI with ignored start mid-flight, then ST in the done cycle
      start_op(16'hA000, 16'h5000, 16'h0000);
      step();
      start_op(16'h3000, 16'h6000, 16'h7777);
      complete_data = 1'b1; Data_dout = 16'h5100;
      step(); mem_start = 1'b0;
      check16("ldi_read_addr", Data_addr, 16'h5100);
      Data_dout = 16'hABCD;
      step(); complete_data = 1'b0;
      check16("ldi_memout", memout, 16'hABCD);
      check16("ldi_done", 16'(mem_done), 16'd1);
      start_op(16'h3000, 16'h6000, 16'h7777);
      step(); mem_start = 1'b0;
      check16("b2b_state", 16'(mem_state), 16'd2);
      check16("b2b_din", Data_din, 16'h7777);
      complete_data = 1'b1;
      step(); complete_data = 1'b0;

      // reset during a WRITE wait
      start_op(16'h7000, 16'h6100, 16'h1111);
      step(); mem_start = 1'b0;
      step(); reset = 1'b1;
      step(); reset = 1'b0;
      check16("rstw_state", 16'(mem_state), 16'd3);
      check16("rstw_addr", Data_addr, 16'h0000);
      check16("rstw_memout", memout, 16'h0000);
      check16("rstw_done", 16'(mem_done), 16'd0);
      start_op(16'h2000, 16'h3010, 16'h0000);
      step(); mem_start = 1'b0;
      complete_data = 1'b1; Data_dout = 16'h55AA;
      step(); complete_data = 1'b0;
      check16("post_rst_memout", memout, 16'h55AA);

      for (int c = 0; c < 3000; c++) begin
         if (c % 64 == 0) begin
            case ($urandom_range(0, 3))
               0: p = 0;
               1: p = 10;
               2: p = 50;
               default: p = 100;
            endcase
         end
         reset         = ($urandom_range(0, 399) == 0);
         mem_start     = ($urandom_range(0, 3) == 0);
         IR_Exec       = {ops[$urandom_range(0, 7)], 12'($urandom)};
         M_Addr        = 16'($urandom);
         M_Data        = 16'($urandom);
         Data_dout     = 16'($urandom);
         complete_data = ($urandom_range(0, 99) < p);
         step();
      end
      reset = 1'b0; mem_start = 1'b0; complete_data = 1'b0;
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lc3_memaccess_fsm.md
Name: lc3_memaccess_fsm

Overview:
- Memory-access stage of the LC3 pipeline. Sits directly downstream of execute and consumes its IR_Exec, M_Addr and M_Data.
- Owns its own mem_state sequencer and drives the data-memory bus through a variable-latency complete_data handshake.
- Supports LD/LDR/LDI/ST/STR/STI, including two-access indirect ops. Has a timeout abort.
- Produces memout for writeback and mem_done/mem_busy for the controller.

Parameters:
- TIMEOUT_CYCLES, 15: max cycles spent in one access state without complete_data before abort (must be >=1).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- mem_start  in  1  one-cycle request; operands valid in the same cycle
- IR_Exec  in  16  instruction; opcode = IR_Exec[15:12]
- M_Addr  in  16  effective address from execute
- M_Data  in  16  store data from execute
- Data_dout  in  16  read data from data memory
- complete_data  in  1  memory access complete this cycle
- Data_addr  out  16  memory address
- Data_din  out  16  memory write data
- Data_rd  out  1  1 = read, 0 = write
- mem_state  out  2  3 = IDLE, 0 = READ, 1 = IND, 2 = WRITE
- memout  out  16  load result to writeback
- mem_busy  out  1  high whenever mem_state != 3
- mem_done  out  1  one-cycle completion pulse
- mem_err  out  1  one-cycle pulse, coincident with mem_done, on timeout

Behaviour:
- Reset (sync, active-high, wins over everything including mid-access):
  - mem_state = 3; memout = 0; Data_addr = 0; Data_din = 0; Data_rd = 1.
  - mem_done = 0; mem_err = 0; timeout counter = 0.
  - A request in flight is dropped; no done pulse is issued.
- IDLE (3):
  - Outputs: Data_rd = 1, Data_addr = 0, Data_din = 0.
  - On mem_start, latch opcode, M_Addr and M_Data into internal registers, then decode:
    - LD 0010 / LDR 0110 -> READ, address = M_Addr.
    - LDI 1010 / STI 1011 -> IND, address = M_Addr.
    - ST 0011 / STR 0111 -> WRITE, address = M_Addr, data = M_Data.
    - Any other opcode -> stay IDLE; mem_done pulses next cycle; no bus activity; memout unchanged.
- READ (0):
  - Outputs: Data_rd = 1, Data_addr = latched address.
  - On complete_data: memout <= Data_dout, mem_done <= 1, next state IDLE.
- IND (1):
  - Outputs: Data_rd = 1, Data_addr = latched address.
  - On complete_data: latched address <= Data_dout. Next state is READ for LDI, WRITE for STI.
  - Pointer read never updates memout.
- WRITE (2):
  - Outputs: Data_rd = 0, Data_addr = latched address, Data_din = latched data.
  - On complete_data: mem_done <= 1, next state IDLE. memout unchanged.
- Registered outputs: all outputs are registered and change on the clock edge that enters a state.
- complete_data sampling:
  - Sampled only in states 0, 1, 2; ignored in IDLE.
  - Earliest useful assertion is the first cycle of the state.
- Latency, start at cycle t with zero-wait memory:
  - LD/ST: state active t+1, done at t+2.
  - LDI/STI: IND at t+1, second access at t+2, done at t+3.
  - Each wait cycle adds 1.
- Timeout:
  - Counter clears on every state entry and increments each cycle in an access state without complete_data.
  - When the count reaches TIMEOUT_CYCLES with complete_data still low: next state IDLE, mem_done = 1, mem_err = 1, memout unchanged.
  - complete_data in the same cycle the count reaches TIMEOUT_CYCLES counts as success.
- mem_start while mem_busy: ignored, and latched operands are unaffected.
- mem_start in the done cycle (state already IDLE): accepted normally, giving back-to-back ops.
- mem_done and mem_err never assert outside the single cycle after completion or abort.

Test Plan:
- LD, IR_Exec=16'h2005, M_Addr=16'h3010, memory returns 16'hBEEF, complete_data in the first READ cycle -> mem_state 3,0,3; Data_rd=1; Data_addr=16'h3010; memout=16'hBEEF with mem_done at t+2.
- STI, M_Addr=16'h3020, M_Data=16'h1234, pointer read returns 16'h4000, 2 wait cycles per access -> IND with Data_addr=16'h3020, then WRITE with Data_addr=16'h4000, Data_din=16'h1234, Data_rd=0; done at t+7; memout unchanged.
- LDR, complete_data held low -> after 15 cycles in READ, mem_done=mem_err=1, state 3, memout unchanged; repeat with complete_data arriving exactly at count 15 -> success, mem_err=0.
- ADD opcode 0001 with mem_start -> mem_done at t+1; mem_state stays 3; Data_rd stays 1; memout unchanged.
- LDI in progress, second mem_start (ST) in IND state -> ignored and LDI completes with correct memout; a mem_start in the done cycle starts the ST immediately.
- Reset asserted during WRITE wait -> next cycle mem_state=3, Data_rd=1, Data_addr=0, memout=0, no mem_done; a following LD works normally.
